// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO behind a UART receiver, one write per RXDONE rising edge, valid/ready read side.
// Ports: CLK/RESET (sync, active-high); RXDATA/RXDONE from receiver; RDATA/RVALID/RREADY consumer
// handshake (first-word-fall-through); COUNT occupancy 0..DEPTH; FULL; OVERFLOW sticky lost-byte flag,
// cleared by OVFCLR. Define UART_RXFIFO_OVERWRITE_EN to discard the oldest byte instead of the newest when full.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [7:0]    RXDATA,
    input  logic          RXDONE,
    output logic [7:0]    RDATA,
    output logic          RVALID,
    input  logic          RREADY,
    output logic [AW:0]   COUNT,
    output logic          FULL,
    output logic          OVERFLOW,
    input  logic          OVFCLR
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d, done_q;
    logic          wr_req, rd_fire, wr_en, rd_adv, ovf_set;

    assign RDATA    = mem_q[rd_ptr_q];
    assign COUNT    = count_q;
    assign RVALID   = count_q != '0;
    assign FULL     = count_q == (AW+1)'(DEPTH);
    assign OVERFLOW = ovf_q;

    always_comb begin
        wr_req  = RXDONE & ~done_q;
        rd_fire = RVALID & RREADY;
        ovf_set = wr_req & FULL & ~rd_fire;
`ifdef UART_RXFIFO_OVERWRITE_EN
        // A write into a full FIFO evicts the head, so the read side advances with it.
        wr_en   = wr_req;
        rd_adv  = rd_fire | ovf_set;
`else
        wr_en   = wr_req & ~ovf_set;
        rd_adv  = rd_fire;
`endif
        wr_ptr_d = wr_en  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_adv ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(wr_en & ~rd_adv) - (AW+1)'(rd_adv & ~wr_en);
        // Set has priority over a coincident clear.
        ovf_d    = ovf_set ? 1'b1 : (OVFCLR ? 1'b0 : ovf_q);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            done_q   <= RXDONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && wr_en) mem_q[wr_ptr_q] <= RXDATA;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef UART_RXFIFO_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET, RXDONE, RREADY, OVFCLR;
    logic [7:0]    RXDATA, RDATA;
    logic          RVALID, FULL, OVERFLOW;
    logic [AW:0]   COUNT;
    int            n_chk = 0;
    int            n_fail = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RESET(RESET), .RXDATA(RXDATA), .RXDONE(RXDONE),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .COUNT(COUNT),
        .FULL(FULL), .OVERFLOW(OVERFLOW), .OVFCLR(OVFCLR)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        RXDATA = b;
        RXDONE = 1'b1;
        step();
        RXDONE = 1'b0;
        step();
    endtask

    initial begin
        RESET = 1'b1; RXDONE = 1'b0; RREADY = 1'b0; OVFCLR = 1'b0; RXDATA = 8'h00;
        step(); step();
        RESET = 1'b0;
        step();
        chk("rst_count", 32'(COUNT), 0);
        chk("rst_rvalid", 32'(RVALID), 0);
        chk("rst_full", 32'(FULL), 0);
        chk("rst_ovf", 32'(OVERFLOW), 0);

        send(8'h41); send(8'h42); send(8'h43);
        chk("basic_count", 32'(COUNT), 3);
        chk("basic_rvalid", 32'(RVALID), 1);
        chk("basic_head", 32'(RDATA), 32'h41);
        RREADY = 1'b1;
        chk("basic_rd0", 32'(RDATA), 32'h41); step();
        chk("basic_rd1", 32'(RDATA), 32'h42); step();
        chk("basic_rd2", 32'(RDATA), 32'h43); step();
        RREADY = 1'b0;
        chk("basic_empty", 32'(RVALID), 0);
        chk("basic_cnt0", 32'(COUNT), 0);

        RREADY = 1'b1; step(); step(); RREADY = 1'b0;
        chk("empty_rd_count", 32'(COUNT), 0);
        chk("empty_rd_rvalid", 32'(RVALID), 0);

        RXDATA = 8'h5A; RXDONE = 1'b1;
        repeat (10) step();
        RXDONE = 1'b0; step();
        chk("long_count", 32'(COUNT), 1);
        chk("long_data", 32'(RDATA), 32'h5A);

        RXDONE = 1'b1; RESET = 1'b1; step();
        chk("rst_mid_count", 32'(COUNT), 0);
        RESET = 1'b0; step(); step();
        chk("rst_hold_count", 32'(COUNT), 0);
        RXDONE = 1'b0; step();

        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("ovf_full", 32'(FULL), 1);
        chk("ovf_pre", 32'(OVERFLOW), 0);
        send(8'h05);
        chk("ovf_set", 32'(OVERFLOW), 1);
        chk("ovf_count", 32'(COUNT), 4);
        RREADY = 1'b1;
        chk("ovf_rd0", 32'(RDATA), OVW ? 32'h02 : 32'h01); step();
        chk("ovf_rd1", 32'(RDATA), OVW ? 32'h03 : 32'h02); step();
        chk("ovf_rd2", 32'(RDATA), OVW ? 32'h04 : 32'h03); step();
        chk("ovf_rd3", 32'(RDATA), OVW ? 32'h05 : 32'h04); step();
        RREADY = 1'b0;
        chk("ovf_drained", 32'(COUNT), 0);
        chk("ovf_sticky", 32'(OVERFLOW), 1);
        OVFCLR = 1'b1; step(); OVFCLR = 1'b0;
        chk("ovf_clr", 32'(OVERFLOW), 0);

        send(8'h11); send(8'h12); send(8'h13); send(8'h14);
        RXDATA = 8'h15; RXDONE = 1'b1; OVFCLR = 1'b1; step();
        RXDONE = 1'b0; OVFCLR = 1'b0;
        chk("ovf_set_wins", 32'(OVERFLOW), 1);
        chk("ovf_set_cnt", 32'(COUNT), 4);
        chk("ovf_set_head", 32'(RDATA), OVW ? 32'h12 : 32'h11);
        step();
        OVFCLR = 1'b1; step(); OVFCLR = 1'b0;
        chk("ovf_clr2", 32'(OVERFLOW), 0);
        RREADY = 1'b1; repeat (4) step(); RREADY = 1'b0;
        chk("ovf_drain2", 32'(COUNT), 0);

        send(8'h21); send(8'h22); send(8'h23); send(8'h24);
        chk("sim_full", 32'(FULL), 1);
        RXDATA = 8'h99; RXDONE = 1'b1; RREADY = 1'b1; step();
        RXDONE = 1'b0; RREADY = 1'b0;
        chk("sim_ovf", 32'(OVERFLOW), 0);
        chk("sim_count", 32'(COUNT), 4);
        RREADY = 1'b1;
        chk("sim_rd0", 32'(RDATA), 32'h22); step();
        chk("sim_rd1", 32'(RDATA), 32'h23); step();
        chk("sim_rd2", 32'(RDATA), 32'h24); step();
        chk("sim_rd3", 32'(RDATA), 32'h99); step();
        RREADY = 1'b0;
        chk("sim_empty", 32'(RVALID), 0);

        for (int i = 0; i < 10; i++) begin
            RXDATA = 8'(8'h10 + i); RXDONE = 1'b1; step();
            RXDONE = 1'b0;
            chk("wrap_data", 32'(RDATA), 32'h10 + 32'(i));
            chk("wrap_count", 32'(COUNT), 1);
            RREADY = 1'b1; step(); RREADY = 1'b0;
        end
        chk("wrap_end", 32'(COUNT), 0);
        chk("wrap_ovf", 32'(OVERFLOW), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
